// File: rtl/mp_miu_arbiter_if.sv
// IU request ports and the shared RAM port of the memory interface unit.
// The arbiter is the slave; the IUs and the RAM together form the master side.
interface mp_miu_arbiter_if #(
    parameter int NUM_IU = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [NUM_IU-1:0]        mem_req;
    logic [NUM_IU-1:0]        mem_we;
    logic [NUM_IU*ADDR_W-1:0] mem_addr;
    logic [NUM_IU*DATA_W-1:0] mem_write;
    logic [DATA_W-1:0]        mem_read;
    logic [NUM_IU-1:0]        mem_done;
    logic                     busy;
    logic                     ram_en;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;

    // Handshake: an IU raises mem_req with we/addr/write stable and holds it until its
    // one-cycle mem_done pulse; mem_read is valid in that cycle. ram_en is a one-cycle
    // strobe and ram_rdata is valid exactly MEM_LAT cycles later.
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_write, ram_rdata,
        output mem_read, mem_done, busy, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output mem_req, mem_we, mem_addr, mem_write, ram_rdata,
        input  mem_read, mem_done, busy, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mp_miu_arbiter.sv
// Round-robin arbiter of NUM_IU memory request ports onto one fixed-latency RAM port,
// one transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
module mp_miu_arbiter #(
    parameter int NUM_IU  = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    mp_miu_arbiter_if.slave  bus,
    output logic [1:0]       fsm_state
);
    localparam int IDX_W = (NUM_IU > 1) ? $clog2(NUM_IU) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  scan_idx;
    logic              pick_valid;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] read_q;

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_IU; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_IU);
            if (!pick_valid && bus.mem_req[scan_idx]) begin
                pick_valid = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.mem_done = '0;
        bus.busy     = (state != IDLE);
        bus.ram_en   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.ram_en = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.mem_done[grant] = 1'b1;
                state_next          = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= IDX_W'(NUM_IU - 1);
            grant   <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick;
                        rr_ptr  <= pick;
                        we_q    <= bus.mem_we[pick];
                        addr_q  <= bus.mem_addr[pick*ADDR_W +: ADDR_W];
                        wdata_q <= bus.mem_write[pick*DATA_W +: DATA_W];
                    end
                end
                ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!we_q) begin
                        // Writes leave mem_read holding the last read result.
                        read_q <= bus.ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.mem_read  = read_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_mp_miu_arbiter.sv
// Bench for mp_miu_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level reference model with a simple RAM behind the DUT.
module tb_mp_miu_arbiter;
    localparam int NUM_IU  = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;
    localparam int TXN     = MEM_LAT + 3;

    logic       clk;
    logic       reset;
    logic [1:0] fsm_state;

    mp_miu_arbiter_if #(.NUM_IU(NUM_IU), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mp_miu_arbiter #(.NUM_IU(NUM_IU), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 16-word RAM indexed by addr[3:0]; upper address bits still travel through the DUT.
    function automatic logic [DATA_W-1:0] init_val(int idx);
        return (idx == 0) ? 32'hDEADBEEF : (32'hC0DE0000 | idx);
    endfunction

    logic [DATA_W-1:0] ram_mem [16];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    logic              rd_vld  [MEM_LAT];
    logic [DATA_W-1:0] junk;
    bit                ram_loaded;

    always @(posedge clk) begin
        junk <= $urandom;
        if (!ram_loaded) begin
            for (int idx = 0; idx < 16; idx++) ram_mem[idx] <= init_val(idx);
            ram_loaded <= 1'b1;
        end else if (bus.ram_en && bus.ram_we) begin
            ram_mem[bus.ram_addr[3:0]] <= bus.ram_wdata;
        end
        rd_vld[0]  <= reset ? 1'b0 : (bus.ram_en && !bus.ram_we);
        rd_pipe[0] <= ram_mem[bus.ram_addr[3:0]];
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign bus.ram_rdata = rd_vld[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : junk;

    // reference model state
    logic [DATA_W-1:0] ref_mem [16];
    int                busy_left;
    int                last_g;
    int                cur_g;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [DATA_W-1:0] cur_rdata;
    logic [DATA_W-1:0] exp_mem_read;
    bit                was_reset;

    // scoreboard
    int                n_cmp;
    int                n_bad;
    int                cyc;
    logic [7:0]        exp_q[$];
    logic [7:0]        obs_q[$];
    int                obs_cyc[$];
    logic [DATA_W-1:0] obs_data[$];

    // stimulus control
    bit                rand_on;
    bit                reset_cmd;
    logic [NUM_IU-1:0] auto_mask;
    logic [NUM_IU-1:0] hold_mask;
    bit                want_v    [NUM_IU];
    logic              want_we   [NUM_IU];
    logic [ADDR_W-1:0] want_addr [NUM_IU];
    logic [DATA_W-1:0] want_data [NUM_IU];
    int                want_cyc  [NUM_IU];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= NUM_IU; k++) begin
            if (bus.mem_req[(last_g + k) % NUM_IU]) return (last_g + k) % NUM_IU;
        end
        return -1;
    endfunction

    task automatic start_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        bus.mem_req[i]                   = 1'b1;
        bus.mem_we[i]                    = we;
        bus.mem_addr[i*ADDR_W +: ADDR_W] = a;
        bus.mem_write[i*DATA_W +: DATA_W] = d;
        want_cyc[i]                      = cyc;
    endtask

    // One cycle: check outputs against the model, update IU stimulus, advance the model.
    task automatic tick();
        logic [NUM_IU-1:0] exp_done;
        int                g;
        @(negedge clk);
        cyc++;
        exp_done = (busy_left == 1) ? (NUM_IU'(1) << cur_g) : '0;
        check_eq("busy", bus.busy, busy_left > 0);
        check_eq("ram_en", bus.ram_en, busy_left == MEM_LAT + 2);
        check_eq("mem_done", bus.mem_done, exp_done);
        check_eq("dbg_state_idle", fsm_state == 2'd0, busy_left == 0);
        if (busy_left == MEM_LAT + 2) begin
            check_eq("ram_we", bus.ram_we, cur_we);
            check_eq("ram_addr", bus.ram_addr, cur_addr);
            if (cur_we) check_eq("ram_wdata", bus.ram_wdata, cur_wdata);
        end
        if (busy_left == 1 && !cur_we) exp_mem_read = cur_rdata;
        if (busy_left <= 1) check_eq("mem_read", bus.mem_read, exp_mem_read);
        if (was_reset) begin
            check_eq("rst_ram_we", bus.ram_we, 1'b0);
            check_eq("rst_ram_addr", bus.ram_addr, '0);
            check_eq("rst_ram_wdata", bus.ram_wdata, '0);
        end
        for (int i = 0; i < NUM_IU; i++) begin
            if (bus.mem_done[i]) begin
                obs_q.push_back(8'(i));
                obs_cyc.push_back(cyc);
                obs_data.push_back(bus.mem_read);
            end
        end

        for (int i = 0; i < NUM_IU; i++) begin
            if (exp_done[i] && !hold_mask[i]) begin
                bus.mem_req[i] = 1'b0;
            end else if (rand_on && bus.mem_req[i] && busy_left > 1 && cur_g == i &&
                         $urandom_range(0, 15) == 0) begin
                bus.mem_req[i]                   = 1'b0;
                bus.mem_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            end else if (!bus.mem_req[i]) begin
                if (want_v[i]) begin
                    start_req(i, want_we[i], want_addr[i], want_data[i]);
                    want_v[i] = 1'b0;
                end else if (auto_mask[i] || (rand_on && $urandom_range(0, 3) == 0)) begin
                    start_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
                end
            end
        end
        reset     = reset_cmd || (rand_on && $urandom_range(0, 299) == 0);
        reset_cmd = 1'b0;

        was_reset = reset;
        if (reset) begin
            busy_left    = 0;
            last_g       = NUM_IU - 1;
            exp_mem_read = '0;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            g = rr_pick();
            if (g >= 0) begin
                cur_g     = g;
                last_g    = g;
                cur_we    = bus.mem_we[g];
                cur_addr  = bus.mem_addr[g*ADDR_W +: ADDR_W];
                cur_wdata = bus.mem_write[g*DATA_W +: DATA_W];
                cur_rdata = ref_mem[cur_addr[3:0]];
                if (cur_we) ref_mem[cur_addr[3:0]] = cur_wdata;
                busy_left = MEM_LAT + 2;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            reset_cmd = 1'b1;
            tick();
        end
        tick();
    endtask

    task automatic want(input int i, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        want_v[i]    = 1'b1;
        want_we[i]   = we;
        want_addr[i] = a;
        want_data[i] = d;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        obs_data.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int k = 0; k < budget && obs_q.size() < n; k++) tick();
        check_eq("done_count", obs_q.size(), n);
    endtask

    task automatic check_order(input string tag);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check_eq(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (busy_left != 0 || bus.mem_req != '0); k++) tick();
        check_eq("drain_idle", busy_left == 0 && bus.mem_req == '0, 1'b1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        reset = 1'b1; reset_cmd = 1'b0; rand_on = 1'b0;
        auto_mask = '0; hold_mask = '0;
        bus.mem_req = '0; bus.mem_we = '0; bus.mem_addr = '0; bus.mem_write = '0;
        for (int i = 0; i < NUM_IU; i++) want_v[i] = 1'b0;
        for (int idx = 0; idx < 16; idx++) ref_mem[idx] = init_val(idx);
        busy_left = 0; last_g = NUM_IU - 1; cur_g = 0; cur_we = 1'b0;
        cur_addr = '0; cur_wdata = '0; cur_rdata = '0; exp_mem_read = '0; was_reset = 1'b1;
        do_reset(3);

        // single read: done MEM_LAT+2 cycles after the request cycle
        clear_obs();
        want(0, 1'b0, 16'h0010, '0);
        wait_done(1, 20);
        if (obs_q.size() == 1) begin
            check_eq("t1_iu", obs_q[0], 0);
            check_eq("t1_latency", obs_cyc[0] - want_cyc[0], MEM_LAT + 2);
            check_eq("t1_data", obs_data[0], 32'hDEADBEEF);
        end

        // write then read back from IU2
        clear_obs();
        want(2, 1'b1, 16'h0040, 32'h12345678);
        wait_done(1, 20);
        if (obs_q.size() == 1) check_eq("t2_wr_hold", obs_data[0], 32'hDEADBEEF);
        clear_obs();
        want(2, 1'b0, 16'h0040, '0);
        wait_done(1, 20);
        if (obs_q.size() == 1) check_eq("t2_rd_data", obs_data[0], 32'h12345678);

        // contention: all four at once, twice
        do_reset(1);
        for (int rep = 0; rep < 2; rep++) begin
            clear_obs();
            for (int i = 0; i < NUM_IU; i++) want(i, 1'b0, 16'(16'h0100 + i), '0);
            wait_done(NUM_IU, 60);
            for (int k = 1; k < obs_cyc.size(); k++)
                check_eq("t3_spacing", obs_cyc[k] - obs_cyc[k-1], TXN);
            for (int i = 0; i < NUM_IU; i++) exp_q.push_back(8'(i));
            check_order("t3_order");
            drain();
        end

        // fairness: IU1 re-requests after every done, IU3 holds its request
        do_reset(1);
        clear_obs();
        auto_mask = 4'b1010;
        hold_mask = 4'b1000;
        wait_done(8, 80);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'd1);
            exp_q.push_back(8'd3);
        end
        check_order("t4_alternate");
        auto_mask = '0;
        hold_mask = '0;
        drain();

        // reset during WAIT aborts; the held IU2 request is granted afterwards
        do_reset(1);
        clear_obs();
        want(2, 1'b0, 16'h0003, '0);
        for (int k = 0; k < 20 && busy_left != MEM_LAT + 1; k++) tick();
        check_eq("t5_reached_wait", busy_left, MEM_LAT + 1);
        tick();
        reset_cmd = 1'b1;
        tick();
        tick();
        check_eq("t5_no_done", obs_q.size(), 0);
        wait_done(1, 20);
        exp_q.push_back(8'd2);
        check_order("t5_regrant");
        drain();

        // random traffic with early drops and occasional resets
        clear_obs();
        rand_on = 1'b1;
        repeat (3000) tick();
        rand_on = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
